// File: rtl/dec_pkg.sv
// Shared sizing and the per-group scan record for the one-hot encoder pipe.
package dec_pkg;

    localparam int unsigned N_IN   = 256;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned GRP_W  = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned N_GRP  = N_IN / GRP_W;
    localparam int unsigned LIDX_W = $clog2(GRP_W);

    typedef struct packed {
        logic              any;
        logic              multi;
        logic [LIDX_W-1:0] lidx;
    } grp_info_t;

endpackage

// File: rtl/dec_grp_scan.sv
// Combinational scan of one group: any bit set, two or more set, lowest set index.
module dec_grp_scan #(
    parameter int unsigned GRP_W  = 16,
    parameter int unsigned LIDX_W = $clog2(GRP_W)
) (
    input  logic [GRP_W-1:0]  grp,
    output logic              any,
    output logic              multi,
    output logic [LIDX_W-1:0] lidx
);

    always_comb begin
        any   = |grp;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = |(grp & (grp - GRP_W'(1)));
        lidx  = '0;
        for (int unsigned i = GRP_W; i > 0; i--) begin
            if (grp[i-1]) begin
                lidx = LIDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/dec_onehot_encoder_pipe.sv
// Two-stage valid/ready pipe recovering the index of a one-hot word, with zero/multi-hot flags
// and saturating transfer/error counters.
module dec_onehot_encoder_pipe #(
    parameter int unsigned N_IN  = dec_pkg::N_IN,
    parameter int unsigned IDX_W = dec_pkg::IDX_W,
    parameter int unsigned GRP_W = dec_pkg::GRP_W,
    parameter int unsigned CNT_W = dec_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_multi,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    import dec_pkg::*;

    localparam int unsigned NG = N_IN / GRP_W;
    localparam int unsigned GW = IDX_W - LIDX_W;

    grp_info_t scan_info [NG];
    grp_info_t s1_info   [NG];
    logic      s1_valid;
    logic      s2_valid;
    logic      s1_adv;
    logic      s2_adv;

    logic              hit;
    logic              multi_grp;
    logic [GW-1:0]     g_sel;
    logic [LIDX_W-1:0] l_sel;
    logic              m_sel;

    logic              xfer;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign xfer      = s2_valid && out_ready;

    for (genvar g = 0; g < NG; g++) begin : g_scan
        dec_grp_scan #(
            .GRP_W  (GRP_W),
            .LIDX_W (LIDX_W)
        ) u_scan (
            .grp   (in_vec[g*GRP_W +: GRP_W]),
            .any   (scan_info[g].any),
            .multi (scan_info[g].multi),
            .lidx  (scan_info[g].lidx)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int unsigned i = 0; i < NG; i++) begin
                s1_info[i] <= '0;
            end
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_info <= scan_info;
            end
        end
    end

    // Lowest occupied group supplies the index; a second occupied group makes the word multi-hot.
    always_comb begin
        hit       = 1'b0;
        multi_grp = 1'b0;
        g_sel     = '0;
        l_sel     = '0;
        m_sel     = 1'b0;
        for (int unsigned i = 0; i < NG; i++) begin
            if (s1_info[i].any) begin
                if (hit) begin
                    multi_grp = 1'b1;
                end else begin
                    hit   = 1'b1;
                    g_sel = GW'(i);
                    l_sel = s1_info[i].lidx;
                    m_sel = s1_info[i].multi;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_idx   <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_idx   <= {g_sel, l_sel};
                out_zero  <= !hit;
                out_multi <= m_sel || multi_grp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr_cnt) begin
            xfer_cnt <= '0;
            err_cnt  <= '0;
        end else if (xfer) begin
            if (xfer_cnt != '1) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            if ((out_zero || out_multi) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dec_onehot_encoder_pipe.sv
// Directed bench for dec_onehot_encoder_pipe; a second instance with 4-bit counters covers saturation.
module tb_dec_onehot_encoder_pipe;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_idx;
    logic         out_zero;
    logic         out_multi;
    logic         clr_cnt;
    logic [15:0]  xfer_cnt;
    logic [15:0]  err_cnt;

    logic         in_ready4;
    logic         out_valid4;
    logic [7:0]   out_idx4;
    logic         out_zero4;
    logic         out_multi4;
    logic [3:0]   xfer4;
    logic [3:0]   err4;

    int tests_run;
    int tests_failed;

    dec_onehot_encoder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .out_multi (out_multi),
        .clr_cnt   (clr_cnt),
        .xfer_cnt  (xfer_cnt),
        .err_cnt   (err_cnt)
    );

    dec_onehot_encoder_pipe #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_vec    (in_vec),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_idx   (out_idx4),
        .out_zero  (out_zero4),
        .out_multi (out_multi4),
        .clr_cnt   (clr_cnt),
        .xfer_cnt  (xfer4),
        .err_cnt   (err4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, failed=%0d", tests_failed);
        $fatal(1);
    end

    function automatic logic [255:0] onehot(input int unsigned k);
        logic [255:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic clear_counters();
        @(negedge clk);
        clr_cnt  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        clr_cnt  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid, out_zero, out_multi, out_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs got rdy=%b v=%b z=%b m=%b idx=%0d want rdy=1 v=0 z=0 m=0 idx=0",
                     in_ready, out_valid, out_zero, out_multi, out_idx);
        end
        tests_run++;
        if ({xfer_cnt, err_cnt} !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_counters got xfer=%0d err=%0d want 0 0", xfer_cnt, err_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_pulse got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_exhaustive();
        clear_counters();
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 258; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (i < 2) begin
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL exh_latency cycle %0d got out_valid=%b want 0", i, out_valid);
                end
            end else if ({in_ready, out_valid, out_zero, out_multi, out_idx} !==
                         {1'b1, 1'b1, 1'b0, 1'b0, 8'(i - 2)}) begin
                tests_failed++;
                $display("FAIL exh_word got rdy=%b v=%b z=%b m=%b idx=%0d want rdy=1 v=1 z=0 m=0 idx=%0d",
                         in_ready, out_valid, out_zero, out_multi, out_idx, i - 2);
            end
            if (i < 256) begin
                in_valid = 1'b1;
                in_vec   = onehot(i);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({xfer_cnt, err_cnt} !== {16'd256, 16'd0}) begin
            tests_failed++;
            $display("FAIL exh_counters got xfer=%0d err=%0d want 256 0", xfer_cnt, err_cnt);
        end
    endtask

    task automatic test_zero_multi();
        logic [255:0] vecs [3];
        logic [7:0]   exp_idx [3];
        logic         exp_zero [3];
        logic         exp_multi [3];
        vecs[0] = '0;
        vecs[1] = onehot(5) | onehot(200);
        vecs[2] = onehot(17) | onehot(18);
        exp_idx   = '{8'd0, 8'd5, 8'd17};
        exp_zero  = '{1'b1, 1'b0, 1'b0};
        exp_multi = '{1'b0, 1'b1, 1'b1};
        clear_counters();
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (i >= 2) begin
                tests_run++;
                if ({out_valid, out_zero, out_multi, out_idx} !==
                    {1'b1, exp_zero[i-2], exp_multi[i-2], exp_idx[i-2]}) begin
                    tests_failed++;
                    $display("FAIL zm_word%0d got v=%b z=%b m=%b idx=%0d want v=1 z=%b m=%b idx=%0d",
                             i - 2, out_valid, out_zero, out_multi, out_idx,
                             exp_zero[i-2], exp_multi[i-2], exp_idx[i-2]);
                end
            end
            if (i < 3) begin
                in_valid = 1'b1;
                in_vec   = vecs[i];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({xfer_cnt, err_cnt} !== {16'd3, 16'd3}) begin
            tests_failed++;
            $display("FAIL zm_counters got xfer=%0d err=%0d want 3 3", xfer_cnt, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_rdy;
        exp_rdy = 3'b011;
        clear_counters();
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_vec   = onehot(i + 1);
            #1;
            tests_run++;
            if (in_ready !== exp_rdy[i]) begin
                tests_failed++;
                $display("FAIL bp_accept%0d got in_ready=%b want %b", i + 1, in_ready, exp_rdy[i]);
            end
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            tests_run++;
            if ({in_ready, out_valid, out_idx} !== {1'b0, 1'b1, 8'd1}) begin
                tests_failed++;
                $display("FAIL bp_hold got rdy=%b v=%b idx=%0d want rdy=0 v=1 idx=1", in_ready, out_valid, out_idx);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, out_valid, out_idx} !== {1'b1, 1'b1, 8'd1}) begin
            tests_failed++;
            $display("FAIL bp_release got rdy=%b v=%b idx=%0d want rdy=1 v=1 idx=1", in_ready, out_valid, out_idx);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int unsigned i = 2; i <= 3; i++) begin
            #1;
            tests_run++;
            if ({out_valid, out_idx} !== {1'b1, 8'(i)}) begin
                tests_failed++;
                $display("FAIL bp_drain got v=%b idx=%0d want v=1 idx=%0d", out_valid, out_idx, i);
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if ({out_valid, xfer_cnt} !== {1'b0, 16'd3}) begin
            tests_failed++;
            $display("FAIL bp_no_dup got v=%b xfer=%0d want v=0 xfer=3", out_valid, xfer_cnt);
        end
    endtask

    task automatic test_saturation();
        clear_counters();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = '0;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({xfer4, err4} !== {4'd15, 4'd15}) begin
            tests_failed++;
            $display("FAIL sat_cnt4 got xfer=%0d err=%0d want 15 15", xfer4, err4);
        end
        tests_run++;
        if ({xfer_cnt, err_cnt} !== {16'd20, 16'd20}) begin
            tests_failed++;
            $display("FAIL sat_cnt16 got xfer=%0d err=%0d want 20 20", xfer_cnt, err_cnt);
        end
        in_valid = 1'b1;
        in_vec   = '0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_setup got out_valid=%b want 1", out_valid);
        end
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, xfer_cnt, err_cnt, xfer4, err4} !== 41'd0) begin
            tests_failed++;
            $display("FAIL clr_on_xfer got v=%b xfer=%0d err=%0d xfer4=%0d err4=%0d want all 0",
                     out_valid, xfer_cnt, err_cnt, xfer4, err4);
        end
    endtask

    task automatic test_random_stalls();
        logic [7:0]  exp_q [$];
        logic [7:0]  exp_k;
        logic        prev_stall;
        logic [10:0] saved;
        int unsigned k;
        prev_stall = 1'b0;
        saved      = '0;
        for (int unsigned cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            #1;
            if (prev_stall) begin
                tests_run++;
                if ({out_valid, out_zero, out_multi, out_idx} !== saved) begin
                    tests_failed++;
                    $display("FAIL rnd_stable got %h want %h", {out_valid, out_zero, out_multi, out_idx}, saved);
                end
            end
            k         = $urandom_range(255, 0);
            in_valid  = 1'($urandom_range(1, 0));
            in_vec    = onehot(k);
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            if (in_valid && in_ready) exp_q.push_back(8'(k));
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rnd_extra got idx=%0d want no output", out_idx);
                end else begin
                    exp_k = exp_q.pop_front();
                    if ({out_zero, out_multi, out_idx} !== {2'b00, exp_k}) begin
                        tests_failed++;
                        $display("FAIL rnd_word got z=%b m=%b idx=%0d want z=0 m=0 idx=%0d",
                                 out_zero, out_multi, out_idx, exp_k);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            saved      = {out_valid, out_zero, out_multi, out_idx};
        end
        for (int unsigned d = 0; d < 10; d++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rnd_drain_extra got idx=%0d want no output", out_idx);
                end else begin
                    exp_k = exp_q.pop_front();
                    if (out_idx !== exp_k) begin
                        tests_failed++;
                        $display("FAIL rnd_drain got idx=%0d want %0d", out_idx, exp_k);
                    end
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rnd_lost got %0d words pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = onehot(7);
        @(negedge clk);
        in_vec   = onehot(8);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_idx, in_ready} !== {1'b1, 8'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_setup got v=%b idx=%0d rdy=%b want v=1 idx=7 rdy=0", out_valid, out_idx, in_ready);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, xfer_cnt, err_cnt} !== 33'd0) begin
            tests_failed++;
            $display("FAIL rst_mid got v=%b xfer=%0d err=%0d want 0 0 0", out_valid, xfer_cnt, err_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_flushed got out_valid=%b idx=%0d want 0", out_valid, out_idx);
        end
        in_valid = 1'b1;
        in_vec   = onehot(9);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_stale got out_valid=%b idx=%0d want 0", out_valid, out_idx);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_idx} !== {1'b1, 8'd9}) begin
            tests_failed++;
            $display("FAIL rst_first_word got v=%b idx=%0d want v=1 idx=9", out_valid, out_idx);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_vec       = '0;
        out_ready    = 1'b0;
        clr_cnt      = 1'b0;
        test_reset();
        test_exhaustive();
        test_zero_multi();
        test_backpressure();
        test_saturation();
        test_random_stalls();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
